// File: rtl/chacha_block.sv
// chacha_block: ChaCha block function over a 16-word state, one quarter-round
// half-step per clock through a single shared datapath.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     word-serial state load, word 0 first
//   in_data[31:0]         state word
//   out_valid/out_ready   word-serial result unload, word 0 first
//   out_data[31:0]        result word (0 whenever out_valid is low)
//   busy                  high while rounds are being computed
//
// Parameter DOUBLE_ROUNDS: column+diagonal round pairs (10 = ChaCha20), 1..15.
// Build macro CHACHA_FEEDFORWARD_EN: when defined, keep a copy of the loaded
// state and add it to the permuted state on output (RFC 8439 block function);
// when undefined, the raw permutation is output. Timing is identical.
module chacha_block #(
  parameter int unsigned DOUBLE_ROUNDS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {LOAD, RUN, OUT} state_e;

  localparam logic [3:0] LAST_DR = 4'(DOUBLE_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  load_idx_q, load_idx_d;
  logic [3:0]  out_idx_q, out_idx_d;
  logic [3:0]  dr_q, dr_d;
  logic [2:0]  qr_q, qr_d;
  logic        sel_q, sel_d;
  logic [31:0] x_q [16];
  logic [31:0] x_d [16];

`ifdef CHACHA_FEEDFORWARD_EN
  logic [31:0] in_q [16];
  logic [31:0] in_d [16];
`endif

  logic [3:0]  ia, ib, ic, id;
  logic [1:0]  j;
  logic [31:0] a0, b0, c0, d0;
  logic [31:0] a1, b1, c1, d1;
  logic [31:0] dx, bx;
  logic [31:0] res_word;

  // Quarter-round operand selection: qr 0..3 are columns, 4..7 diagonals.
  always_comb begin
    j = qr_q[1:0];
    if (!qr_q[2]) begin
      ia = {2'b00, j};
      ib = {2'b01, j};
      ic = {2'b10, j};
      id = {2'b11, j};
    end else begin
      ia = {2'b00, j};
      ib = {2'b01, j + 2'd1};
      ic = {2'b10, j + 2'd2};
      id = {2'b11, j + 2'd3};
    end
  end

  // Shared half-step: sel=0 uses rotations 16/12, sel=1 uses 8/7.
  always_comb begin
    a0 = x_q[ia];
    b0 = x_q[ib];
    c0 = x_q[ic];
    d0 = x_q[id];
    a1 = a0 + b0;
    dx = d0 ^ a1;
    d1 = sel_q ? {dx[23:0], dx[31:24]} : {dx[15:0], dx[31:16]};
    c1 = c0 + d1;
    bx = b0 ^ c1;
    b1 = sel_q ? {bx[24:0], bx[31:25]} : {bx[19:0], bx[31:20]};
  end

  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    out_idx_d  = out_idx_q;
    dr_d       = dr_q;
    qr_d       = qr_q;
    sel_d      = sel_q;
    x_d        = x_q;
`ifdef CHACHA_FEEDFORWARD_EN
    in_d       = in_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          x_d[load_idx_q] = in_data;
`ifdef CHACHA_FEEDFORWARD_EN
          in_d[load_idx_q] = in_data;
`endif
          load_idx_d = load_idx_q + 4'd1;
          if (load_idx_q == 4'd15) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        x_d[ia] = a1;
        x_d[ib] = b1;
        x_d[ic] = c1;
        x_d[id] = d1;
        sel_d   = ~sel_q;
        if (sel_q) begin
          qr_d = qr_q + 3'd1;
          if (qr_q == 3'd7) begin
            if (dr_q == LAST_DR) begin
              dr_d    = '0;
              state_d = OUT;
            end else begin
              dr_d = dr_q + 4'd1;
            end
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          out_idx_d = out_idx_q + 4'd1;
          if (out_idx_q == 4'd15) begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      load_idx_q <= '0;
      out_idx_q  <= '0;
      dr_q       <= '0;
      qr_q       <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      out_idx_q  <= out_idx_d;
      dr_q       <= dr_d;
      qr_q       <= qr_d;
      sel_q      <= sel_d;
    end
  end

  always_ff @(posedge clk) begin
    x_q <= x_d;
  end

`ifdef CHACHA_FEEDFORWARD_EN
  always_ff @(posedge clk) begin
    in_q <= in_d;
  end

  always_comb begin
    res_word = x_q[out_idx_q] + in_q[out_idx_q];
  end
`else
  always_comb begin
    res_word = x_q[out_idx_q];
  end
`endif

  always_comb begin
    in_ready  = (state_q == LOAD);
    busy      = (state_q == RUN);
    out_valid = (state_q == OUT);
    out_data  = (state_q == OUT) ? res_word : '0;
  end

endmodule
